axil_order_receiver: RTL

- AXI-lite slave at the accelerator core's control boundary; sits directly downstream of the host/order-issuing master.
- Host writes order fields into staging registers 0x00-0x44, then writes 0x48 to push the assembled order into an order FIFO.
- Host polls 0x4C, which is non-zero when the FIFO can accept a push.
- The core's scheduler pops orders through a valid/ready interface.

---
 rtl/axil_order_receiver.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_order_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : axil_order_receiver                                               |
// | AXI-lite slave: host fills staging words, a write to 0x48 pushes them as   |
// | one order into a FIFO that the scheduler drains over valid/ready.          |
// | Option : define ORDER_ACCEPT_COUNTER_EN for accept/reject counters at      |
// |          0x54/0x58.                                                        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module axil_order_receiver #(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 8,
  parameter int ORDER_REGS      = 18,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                   system_clk,
  input  logic                                   system_rst,
  input  logic [AXIL_ADDR_WIDTH-1:0]             s_axi_awaddr,
  input  logic                                   s_axi_awvalid,
  output logic                                   s_axi_awready,
  input  logic [AXIL_DATA_WIDTH-1:0]             s_axi_wdata,
  input  logic [AXIL_DATA_WIDTH/8-1:0]           s_axi_wstrb,
  input  logic                                   s_axi_wvalid,
  output logic                                   s_axi_wready,
  output logic [1:0]                             s_axi_bresp,
  output logic                                   s_axi_bvalid,
  input  logic                                   s_axi_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0]             s_axi_araddr,
  input  logic                                   s_axi_arvalid,
  output logic                                   s_axi_arready,
  output logic [AXIL_DATA_WIDTH-1:0]             s_axi_rdata,
  output logic [1:0]                             s_axi_rresp,
  output logic                                   s_axi_rvalid,
  input  logic                                   s_axi_rready,
  output logic                                   order_valid,
  output logic [AXIL_DATA_WIDTH*ORDER_REGS-1:0]  order_data,
  input  logic                                   order_ready,
  output logic [$clog2(FIFO_DEPTH):0]            fifo_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int IDX_W   = AXIL_ADDR_WIDTH - 2;
  localparam int STRB_W  = AXIL_DATA_WIDTH / 8;
  localparam int ORDER_W = AXIL_DATA_WIDTH * ORDER_REGS;

  localparam logic [IDX_W-1:0] c_idx_nregs  = IDX_W'(ORDER_REGS);
  localparam logic [IDX_W-1:0] c_idx_push   = IDX_W'('h48 >> 2);
  localparam logic [IDX_W-1:0] c_idx_status = IDX_W'('h4C >> 2);
  localparam logic [IDX_W-1:0] c_idx_count  = IDX_W'('h50 >> 2);
`ifdef ORDER_ACCEPT_COUNTER_EN
  localparam logic [IDX_W-1:0] c_idx_acc    = IDX_W'('h54 >> 2);
  localparam logic [IDX_W-1:0] c_idx_rej    = IDX_W'('h58 >> 2);
`endif

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e                     w_state_q, w_state_d;
  rstate_e                     r_state_q, r_state_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [AXIL_DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;

  logic [AXIL_DATA_WIDTH-1:0]  stage_q [ORDER_REGS];
  logic [ORDER_W-1:0]          w_stage_flat;
  logic [ORDER_W-1:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]            count_q;

  logic [IDX_W-1:0]            w_aw_idx, w_ar_idx;
  logic                        w_stage_we, w_push_req, w_push, w_pop, w_full;
  logic [AXIL_DATA_WIDTH-1:0]  w_rd_data;
  logic [1:0]                  w_rd_resp;
  logic                        w_unused_addr_lsbs;

  assign w_aw_idx           = s_axi_awaddr[AXIL_ADDR_WIDTH-1:2];
  assign w_ar_idx           = s_axi_araddr[AXIL_ADDR_WIDTH-1:2];
  assign w_unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // The full check deliberately ignores a same-cycle pop.
  assign w_full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign w_push      = w_push_req && !w_full;
  assign order_valid = (count_q != '0);
  assign w_pop       = order_valid && order_ready;
  assign order_data  = mem_q[rd_ptr_q];
  assign fifo_count  = count_q;

  assign s_axi_bresp = bresp_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

  // ---------------------------------------------------------------- write FSM
  always_comb begin
    w_state_d     = w_state_q;
    bresp_d       = bresp_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    w_stage_we    = 1'b0;
    w_push_req    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && s_axi_wvalid) begin
          s_axi_awready = 1'b1;
          s_axi_wready  = 1'b1;
          w_state_d     = W_RESP;
          if (w_aw_idx < c_idx_nregs) begin
            w_stage_we = 1'b1;
            bresp_d    = c_resp_okay;
          end else begin
            case (w_aw_idx)
              c_idx_push: begin
                w_push_req = 1'b1;
                bresp_d    = w_full ? c_resp_slverr : c_resp_okay;
              end
              c_idx_status, c_idx_count: bresp_d = c_resp_okay;
`ifdef ORDER_ACCEPT_COUNTER_EN
              c_idx_acc, c_idx_rej:      bresp_d = c_resp_okay;
`endif
              default:                   bresp_d = c_resp_decerr;
            endcase
          end
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge system_clk or posedge system_rst) begin
    if (system_rst) begin
      w_state_q <= W_IDLE;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      bresp_q   <= bresp_d;
    end
  end

  // ------------------------------------------------------------ staging words
  always_ff @(posedge system_clk or posedge system_rst) begin
    if (system_rst) begin
      for (int i = 0; i < ORDER_REGS; i++) stage_q[i] <= '0;
    end else if (w_stage_we) begin
      for (int i = 0; i < ORDER_REGS; i++) begin
        if (w_aw_idx == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) stage_q[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < ORDER_REGS; gi++) begin : g_flat
    assign w_stage_flat[AXIL_DATA_WIDTH*gi +: AXIL_DATA_WIDTH] = stage_q[gi];
  end

  // --------------------------------------------------------------- order FIFO
  always_ff @(posedge system_clk) begin
    if (w_push) mem_q[wr_ptr_q] <= w_stage_flat;
  end

  always_ff @(posedge system_clk or posedge system_rst) begin
    if (system_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ORDER_ACCEPT_COUNTER_EN
  logic [31:0] accept_cnt_q, reject_cnt_q;

  always_ff @(posedge system_clk or posedge system_rst) begin
    if (system_rst) begin
      accept_cnt_q <= '0;
      reject_cnt_q <= '0;
    end else begin
      if (w_push)                accept_cnt_q <= accept_cnt_q + 1'b1;
      if (w_push_req && w_full)  reject_cnt_q <= reject_cnt_q + 1'b1;
    end
  end
`endif

  // ----------------------------------------------------------------- read map
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = c_resp_okay;
    if (w_ar_idx < c_idx_nregs) begin
      for (int i = 0; i < ORDER_REGS; i++) begin
        if (w_ar_idx == IDX_W'(i)) w_rd_data = stage_q[i];
      end
    end else begin
      case (w_ar_idx)
        c_idx_push:   w_rd_data = '0;
        c_idx_status: w_rd_data = {{(AXIL_DATA_WIDTH-1){1'b0}}, !w_full};
        c_idx_count:  w_rd_data = {{(AXIL_DATA_WIDTH-CNT_W){1'b0}}, count_q};
`ifdef ORDER_ACCEPT_COUNTER_EN
        c_idx_acc:    w_rd_data = accept_cnt_q;
        c_idx_rej:    w_rd_data = reject_cnt_q;
`endif
        default:      w_rd_resp = c_resp_decerr;
      endcase
    end
  end

  // ----------------------------------------------------------------- read FSM
  always_comb begin
    r_state_d     = r_state_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          s_axi_arready = 1'b1;
          rdata_d       = w_rd_data;
          rresp_d       = w_rd_resp;
          r_state_d     = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_state_d = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge system_clk or posedge system_rst) begin
    if (system_rst) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule
`default_nettype wire
